mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameters: none; all datapath widths SHALL be fixed at 32 bits and register addresses at 5 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  issue request; sampled on posedge clk.
REQ-005 funct3  input  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 rs1_data  input  32  operand A (dividend / multiplicand), from register file read port 1.
REQ-007 rs2_data  input  32  operand B (divisor / multiplier), from register file read port 2.
REQ-008 rd_in  input  5  destination register of the issued op.
REQ-009 busy  output  1  high while an op is in flight; issue stage SHALL stall on it.
REQ-010 done  output  1  one-cycle pulse when the result is valid.
REQ-011 rd_addr  output  5  register file write address; nonzero only in the done cycle.
REQ-012 rd_data  output  32  register file write data; valid in the done cycle.

Function
REQ-013 States SHALL be IDLE, MUL, DIV and DONE.
REQ-014 IDLE: start=1 SHALL latch funct3, rs1_data, rs2_data and rd_in, then move to MUL (funct3[2]=0) or DIV (funct3[2]=1).
REQ-015 MUL and DIV SHALL each run exactly 32 iterations, one bit per cycle: shift-add multiply or restoring divide.
REQ-016 After the 32nd iteration the block SHALL enter DONE for exactly one cycle, then return to IDLE.
REQ-017 Latency is fixed for every op, including special cases: start sampled at edge T gives done=1 in the cycle after edge T+33.
REQ-018 busy SHALL be 1 in every non-IDLE state, including DONE; busy SHALL be 0 in IDLE.
REQ-019 start while busy=1, including the DONE cycle, SHALL be ignored with no effect on the in-flight op.
REQ-020 Back-to-back issue: start in the first IDLE cycle after DONE SHALL be accepted.
REQ-021 Operands and rd SHALL be captured at issue; later input changes SHALL NOT affect the result.
REQ-022 MUL SHALL return the low 32 bits of the product; MULH, MULHSU and MULHU the high 32 bits of the 64-bit product (signed*signed, signed*unsigned, unsigned*unsigned).
REQ-023 DIV and REM SHALL use signed operands with quotient truncated toward zero; the remainder SHALL take the sign of the dividend.
REQ-024 DIVU and REMU SHALL use unsigned operands.
REQ-025 Divide by zero: DIV and DIVU SHALL return 0xFFFFFFFF; REM and REMU SHALL return rs1.
REQ-026 Signed overflow (0x80000000 / 0xFFFFFFFF): DIV SHALL return 0x80000000 and REM SHALL return 0.
REQ-027 In the done cycle, rd_addr SHALL equal the latched rd and rd_data the result.
REQ-028 In all other cycles rd_addr and rd_data SHALL be 0, so the register file sees no write.
REQ-029 Latched rd = 0: the op SHALL still execute with full latency, and done SHALL pulse with rd_addr=0, giving no architectural write.
REQ-030 done and busy SHALL be registered outputs with no combinational path from start.

Reset
REQ-031 rst=1 at a posedge SHALL force IDLE with busy=0, done=0, rd_addr=0 and rd_data=0, and SHALL clear all datapath registers.
REQ-032 rst SHALL take priority over start.
REQ-033 Reset mid-operation SHALL abandon the op with no done pulse and no write.
REQ-034 The first start after rst deasserts SHALL be accepted.

Verification
REQ-035 MUL: rs1=7, rs2=0xFFFFFFFD, rd=5 -> done exactly 33 cycles after issue, rd_addr=5, rd_data=0xFFFFFFEB; busy low the next cycle.
REQ-036 MULH/MULHU: 0x80000000*0x80000000 -> 0x40000000 for both; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
REQ-037 Div corners: DIVU 100/0 -> 0xFFFFFFFF; REMU 100%0 -> 100; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same pair -> 0; REM -7%2 -> 0xFFFFFFFF.
REQ-038 Issue DIVU 10/3, pulse start with other operands at cycles 5 and 33 -> single done with rd_data=3; new start accepted the cycle after DONE.
REQ-039 Assert rst at cycle 10 of a DIV -> busy=0 next cycle, no done pulse, rd_addr stays 0; next op completes correctly.
REQ-040 rd_in=0 with MUL 3*4 -> done pulses at the normal time with rd_addr=0; rd_addr=0 in every cycle of every test except done cycles.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit.
// One operation in flight at a time: 32 shift-add or restoring-divide steps,
// a final sign/special-case fixup that registers the result, then a single
// DONE cycle that presents the register-file write.
module mul_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [4:0]  rd_in,
    output logic        busy,
    output logic        done,
    output logic [4:0]  rd_addr,
    output logic [31:0] rd_data
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t      state;
    state_t      state_nxt;

    // Issue-time snapshot of the request
    logic [2:0]  op;
    logic [4:0]  rd_q;
    logic [31:0] a_raw;
    logic [31:0] b_raw;

    // Iteration datapath. Multiply: acc = partial product, mcand = shifted
    // multiplicand magnitude, mplier = remaining multiplier bits.
    // Divide: acc = {remainder, dividend/quotient}, mplier = divisor magnitude.
    logic [63:0] acc;
    logic [63:0] mcand;
    logic [31:0] mplier;
    logic        neg_hi;
    logic        neg_lo;
    logic [5:0]  cnt;
    logic        last;

    // Issue-time sign decode
    logic signed [31:0] rs1_s;
    logic signed [31:0] rs2_s;
    logic        iss_sa;
    logic        iss_sb;

    // Restoring-divide step
    logic [32:0] div_trial;
    logic [32:0] div_diff;

    // Final result
    logic [63:0] prod_fix;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;
    logic [31:0] result;

    function automatic logic [31:0] cneg32(input logic [31:0] v, input logic n);
        return n ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [63:0] cneg64(input logic [63:0] v, input logic n);
        return n ? (~v + 64'd1) : v;
    endfunction

    assign last = (cnt == 6'd32);
    assign busy = (state != IDLE);

    // Decide which operands are treated as signed for the requested op
    always_comb begin
        rs1_s  = rs1_data;
        rs2_s  = rs2_data;
        iss_sa = 1'b0;
        iss_sb = 1'b0;
        if (funct3[2]) begin
            // DIV/REM signed, DIVU/REMU unsigned
            iss_sa = ~funct3[0] & (rs1_s < 0);
            iss_sb = ~funct3[0] & (rs2_s < 0);
        end else begin
            // MULH: both signed; MULHSU: rs1 signed only; MUL low bits are sign-agnostic
            iss_sa = ((funct3[1:0] == 2'b01) || (funct3[1:0] == 2'b10)) && (rs1_s < 0);
            iss_sb = (funct3[1:0] == 2'b01) && (rs2_s < 0);
        end
    end

    // One restoring-divide trial subtraction
    always_comb begin
        div_trial = {acc[63:32], acc[31]};
        div_diff  = div_trial - {1'b0, mplier};
    end

    // Sign fixup and architectural special cases for the finished op
    always_comb begin
        prod_fix = cneg64(acc, neg_lo);
        quot_fix = cneg32(acc[31:0], neg_lo);
        rem_fix  = cneg32(acc[63:32], neg_hi);
        result   = 32'd0;
        if (!op[2]) begin
            result = (op[1:0] == 2'b00) ? prod_fix[31:0] : prod_fix[63:32];
        end else if (b_raw == 32'd0) begin
            result = op[1] ? a_raw : 32'hFFFF_FFFF;
        end else begin
            // Signed overflow falls out naturally: |a|=2^31, |b|=1, no negation
            result = op[1] ? rem_fix : quot_fix;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = funct3[2] ? DIV : MUL;
            MUL:     if (last)  state_nxt = DONE;
            DIV:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, iteration steps and registered write-port outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            op      <= 3'd0;
            rd_q    <= 5'd0;
            a_raw   <= 32'd0;
            b_raw   <= 32'd0;
            acc     <= 64'd0;
            mcand   <= 64'd0;
            mplier  <= 32'd0;
            neg_hi  <= 1'b0;
            neg_lo  <= 1'b0;
            cnt     <= 6'd0;
            done    <= 1'b0;
            rd_addr <= 5'd0;
            rd_data <= 32'd0;
        end else begin
            done    <= 1'b0;
            rd_addr <= 5'd0;
            rd_data <= 32'd0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op     <= funct3;
                        rd_q   <= rd_in;
                        a_raw  <= rs1_data;
                        b_raw  <= rs2_data;
                        cnt    <= 6'd0;
                        mplier <= cneg32(rs2_data, iss_sb);
                        if (funct3[2]) begin
                            acc    <= {32'd0, cneg32(rs1_data, iss_sa)};
                            mcand  <= 64'd0;
                            neg_lo <= iss_sa ^ iss_sb;
                            neg_hi <= iss_sa;
                        end else begin
                            acc    <= 64'd0;
                            mcand  <= {32'd0, cneg32(rs1_data, iss_sa)};
                            neg_lo <= iss_sa ^ iss_sb;
                            neg_hi <= iss_sa ^ iss_sb;
                        end
                    end
                end
                MUL: begin
                    if (last) begin
                        done    <= 1'b1;
                        rd_addr <= rd_q;
                        rd_data <= result;
                    end else begin
                        if (mplier[0]) acc <= acc + mcand;
                        mcand  <= {mcand[62:0], 1'b0};
                        mplier <= {1'b0, mplier[31:1]};
                        cnt    <= cnt + 6'd1;
                    end
                end
                DIV: begin
                    if (last) begin
                        done    <= 1'b1;
                        rd_addr <= rd_q;
                        rd_data <= result;
                    end else begin
                        if (!div_diff[32]) acc <= {div_diff[31:0], acc[30:0], 1'b1};
                        else               acc <= {div_trial[31:0], acc[30:0], 1'b0};
                        cnt <= cnt + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corners, randomized ops
// against an arithmetic reference model, start-while-busy, mid-op reset.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] rs1_data = 32'd0;
    logic [31:0] rs2_data = 32'd0;
    logic [4:0]  rd_in = 5'd0;
    logic        busy;
    logic        done;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mul_div_unit dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .funct3   (funct3),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rd_in    (rd_in),
        .busy     (busy),
        .done     (done),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    // The write port must be silent whenever done is low
    always @(negedge clk) begin
        if (done !== 1'b1 && (rd_addr !== 5'd0 || rd_data !== 32'd0)) begin
            fails++;
            $display("FAIL idle_write t=%0t: rd_addr=%0d rd_data=%h, required 0/0", $time, rd_addr, rd_data);
        end
    end

    // Reference model straight from the RV32M definitions
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] x;
        logic signed [63:0] y;
        logic [63:0]        p;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [31:0] sr;
        sa = a;
        sb = b;
        p  = 64'd0;
        sr = 32'sd0;
        case (f)
            3'd0: return a * b;
            3'd1: begin x = {{32{a[31]}}, a}; y = {{32{b[31]}}, b}; p = x * y; return p[63:32]; end
            3'd2: begin x = {{32{a[31]}}, a}; y = {32'd0, b};       p = x * y; return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                sr = sa / sb; return sr;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                sr = sa % sb; return sr;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic scramble();
        funct3   = 3'($urandom);
        rs1_data = $urandom;
        rs2_data = $urandom;
        rd_in    = 5'($urandom);
    endtask

    // Present a request for one edge, then garble the inputs
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        funct3   = f;
        rs1_data = a;
        rs2_data = b;
        rd_in    = rd;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        scramble();
    endtask

    // Cycles after issue until done; -1 if it never comes
    task automatic wait_done(output int lat, output logic [31:0] d, output logic [4:0] ad);
        lat = -1;
        d   = 32'd0;
        ad  = 5'd0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                lat = k;
                d   = rd_data;
                ad  = rd_addr;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        funct3 = 3'd0; rs1_data = 32'd5; rs2_data = 32'd6; rd_in = 5'd3;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (busy !== 1'b0)     begin fails++; $display("FAIL reset_busy: got %b, required 0", busy); end
        tests++; if (done !== 1'b0)     begin fails++; $display("FAIL reset_done: got %b, required 0", done); end
        tests++; if (rd_addr !== 5'd0)  begin fails++; $display("FAIL reset_rd_addr: got %0d, required 0", rd_addr); end
        tests++; if (rd_data !== 32'd0) begin fails++; $display("FAIL reset_rd_data: got %h, required 0", rd_data); end
        start = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        tests++; if (busy !== 1'b0)     begin fails++; $display("FAIL reset_idle_busy: got %b, required 0", busy); end
    endtask

    task automatic test_directed();
        logic [2:0]  vf [11] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd5, 3'd7, 3'd4, 3'd6, 3'd6, 3'd4, 3'd6};
        logic [31:0] va [11] = '{32'd7, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'd100, 32'd100,
                                 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFB, 32'hFFFF_FFFB};
        logic [31:0] vb [11] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0,
                                 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0};
        logic [31:0] ve [11] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100,
                                 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFB};
        int          lat;
        logic [31:0] d;
        logic [4:0]  ad;
        for (int i = 0; i < 11; i++) begin
            issue(vf[i], va[i], vb[i], 5'(i + 5));
            wait_done(lat, d, ad);
            tests++; if (lat != 33)         begin fails++; $display("FAIL dir%0d_latency: got %0d, required 33", i, lat); end
            tests++; if (d !== ve[i])       begin fails++; $display("FAIL dir%0d_data: got %h, required %h", i, d, ve[i]); end
            tests++; if (ad !== 5'(i + 5))  begin fails++; $display("FAIL dir%0d_rd_addr: got %0d, required %0d", i, ad, i + 5); end
            tests++; if (busy !== 1'b1)     begin fails++; $display("FAIL dir%0d_busy_in_done: got %b, required 1", i, busy); end
            @(posedge clk); #1;
            tests++; if (busy !== 1'b0)     begin fails++; $display("FAIL dir%0d_busy_after: got %b, required 0", i, busy); end
            tests++; if (done !== 1'b0)     begin fails++; $display("FAIL dir%0d_done_width: got %b, required 0", i, done); end
        end
    endtask

    task automatic test_random();
        int          lat;
        logic [31:0] d;
        logic [4:0]  ad;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        for (int i = 0; i < 40; i++) begin
            f  = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 20));
                3: b = -32'($urandom_range(1, 20));
                default: ;
            endcase
            rd  = 5'($urandom_range(1, 31));
            exp = model(f, a, b);
            issue(f, a, b, rd);
            wait_done(lat, d, ad);
            tests++; if (lat != 33) begin fails++; $display("FAIL rnd%0d_latency: got %0d, required 33", i, lat); end
            tests++; if (d !== exp) begin fails++; $display("FAIL rnd%0d_data f=%0d a=%h b=%h: got %h, required %h", i, f, a, b, d, exp); end
            tests++; if (ad !== rd) begin fails++; $display("FAIL rnd%0d_rd_addr: got %0d, required %0d", i, ad, rd); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ignore_start();
        int          ndone = 0;
        int          at = -1;
        logic [31:0] d = 32'd0;
        logic [4:0]  ad = 5'd0;
        logic        busy34 = 1'b1;
        int          lat;
        issue(3'd5, 32'd10, 32'd3, 5'd7);
        for (int k = 1; k <= 34; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                ndone++;
                if (ndone == 1) begin at = k; d = rd_data; ad = rd_addr; end
            end
            if (k == 34) begin
                busy34 = busy;
                start  = 1'b0;
            end else if (k == 5 || k == 33) begin
                scramble();
                rd_in = 5'($urandom_range(1, 31));
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        tests++; if (ndone != 1)      begin fails++; $display("FAIL ign_done_count: got %0d, required 1", ndone); end
        tests++; if (at != 33)        begin fails++; $display("FAIL ign_latency: got %0d, required 33", at); end
        tests++; if (d !== 32'd3)     begin fails++; $display("FAIL ign_data: got %h, required 3", d); end
        tests++; if (ad !== 5'd7)     begin fails++; $display("FAIL ign_rd_addr: got %0d, required 7", ad); end
        tests++; if (busy34 !== 1'b0) begin fails++; $display("FAIL ign_busy_after_done: got %b, required 0", busy34); end
        issue(3'd7, 32'd10, 32'd3, 5'd9);
        wait_done(lat, d, ad);
        tests++; if (lat != 33)       begin fails++; $display("FAIL b2b_latency: got %0d, required 33", lat); end
        tests++; if (d !== 32'd1)     begin fails++; $display("FAIL b2b_data: got %h, required 1", d); end
        tests++; if (ad !== 5'd9)     begin fails++; $display("FAIL b2b_rd_addr: got %0d, required 9", ad); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int          lat;
        logic [31:0] d;
        logic [4:0]  ad;
        logic [31:0] a;
        logic [31:0] b;
        issue(3'd4, 32'hFFFF_FF00, 32'd7, 5'd12);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests++; if (busy !== 1'b0)    begin fails++; $display("FAIL rstmid_busy: got %b, required 0", busy); end
        tests++; if (done !== 1'b0)    begin fails++; $display("FAIL rstmid_done: got %b, required 0", done); end
        tests++; if (rd_addr !== 5'd0) begin fails++; $display("FAIL rstmid_rd_addr: got %0d, required 0", rd_addr); end
        a = $urandom;
        b = 32'($urandom_range(1, 1000));
        issue(3'd4, a, b, 5'd13);
        wait_done(lat, d, ad);
        tests++; if (lat != 33)             begin fails++; $display("FAIL rstmid_next_latency: got %0d, required 33", lat); end
        tests++; if (d !== model(3'd4, a, b)) begin fails++; $display("FAIL rstmid_next_data: got %h, required %h", d, model(3'd4, a, b)); end
        tests++; if (ad !== 5'd13)          begin fails++; $display("FAIL rstmid_next_rd_addr: got %0d, required 13", ad); end
        @(posedge clk); #1;
    endtask

    task automatic test_rd_zero();
        int          lat;
        logic [31:0] d;
        logic [4:0]  ad;
        issue(3'd0, 32'd3, 32'd4, 5'd0);
        wait_done(lat, d, ad);
        tests++; if (lat != 33)    begin fails++; $display("FAIL rd0_latency: got %0d, required 33", lat); end
        tests++; if (ad !== 5'd0)  begin fails++; $display("FAIL rd0_rd_addr: got %0d, required 0", ad); end
        tests++; if (d !== 32'd12) begin fails++; $display("FAIL rd0_data: got %h, required c", d); end
        @(posedge clk); #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rd0_busy_after: got %b, required 0", busy); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_reset_mid();
        test_rd_zero();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
